// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: forwarding selects and divider FSM states.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  // The memory-stage producer is younger than write-back, so it wins.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_div_fsm.sv
// Sequences the multi-cycle divider: start, wait for result, cancel on exception,
// and flags a sticky timeout when the divider stays busy too long.
module hazard_div_fsm
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MAX_DIV_CYCLES = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic i_divE,
  input  logic i_div_ready,
  input  logic i_exc_flush,
  output logic o_div_start,
  output logic o_div_annul,
  output logic o_stall_div,
  output logic o_div_timeout
);

  localparam int unsigned CW = $clog2(MAX_DIV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIV_CYCLES);

  div_state_t    r_state;
  div_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == DIV_BUSY && r_cnt == CNT_MAX)
        r_timeout <= 1'b1;
    end
  end

  // Pulses are suppressed while rst is high so a reset in BUSY never annuls.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_div_start = 1'b0;
    o_div_annul = 1'b0;
    o_stall_div = 1'b0;
    if (!rst) begin
      case (r_state)
        DIV_IDLE: begin
          if (i_divE && !i_exc_flush) begin
            o_div_start = 1'b1;
            o_stall_div = 1'b1;
            w_state_nxt = DIV_BUSY;
            w_cnt_nxt   = '0;
          end
        end
        DIV_BUSY: begin
          if (i_exc_flush) begin
            o_div_annul = 1'b1;
            w_state_nxt = DIV_IDLE;
          end else if (i_div_ready) begin
            w_state_nxt = DIV_IDLE;
          end else begin
            o_stall_div = 1'b1;
            if (r_cnt != CNT_MAX)
              w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = DIV_IDLE;
      endcase
    end
  end

  assign o_div_timeout = r_timeout;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use / branch stalls, and
// divider sequencing that holds the pipeline while a division is in flight.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned MAX_DIV_CYCLES = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              divE,
  input  logic              hiloreadE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic              hilowriteM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  input  logic              hilowriteW,
  input  logic              div_ready,
  input  logic              exc_flush,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic [1:0]        forwardhiloE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushE,
  output logic              div_start,
  output logic              div_annul,
  output logic              div_timeout
);

  logic w_weE_nz;
  logic w_weM_nz;
  logic w_lwstall;
  logic w_branchstall;
  logic w_stall_div;
  logic w_rs_dep;
  logic w_rt_dep;

  // Forwarding
  assign forwardaD = (rsD != '0) && regwriteM && (writeregM == rsD);
  assign forwardbD = (rtD != '0) && regwriteM && (writeregM == rtD);

  assign forwardaE = fwd_sel((rsE != '0) && regwriteM && (writeregM == rsE),
                             (rsE != '0) && regwriteW && (writeregW == rsE));
  assign forwardbE = fwd_sel((rtE != '0) && regwriteM && (writeregM == rtE),
                             (rtE != '0) && regwriteW && (writeregW == rtE));
  assign forwardhiloE = fwd_sel(hiloreadE && hilowriteM, hiloreadE && hilowriteW);

  // Stall detection
  assign w_weE_nz  = (writeregE != '0);
  assign w_weM_nz  = (writeregM != '0);

  assign w_lwstall = memtoregE && regwriteE && w_weE_nz &&
                     ((writeregE == rsD) || (writeregE == rtD));

  assign w_rs_dep = (regwriteE && w_weE_nz && (writeregE == rsD)) ||
                    (memtoregM && w_weM_nz && (writeregM == rsD));
  assign w_rt_dep = (regwriteE && w_weE_nz && (writeregE == rtD)) ||
                    (memtoregM && w_weM_nz && (writeregM == rtD));

  // A jump-register only reads rs, so rt dependencies matter only for branches.
  assign w_branchstall = ((branchD || jrD) && w_rs_dep) || (branchD && w_rt_dep);

  hazard_div_fsm #(
    .MAX_DIV_CYCLES (MAX_DIV_CYCLES)
  ) u_div_fsm (
    .clk           (clk),
    .rst           (rst),
    .i_divE        (divE),
    .i_div_ready   (div_ready),
    .i_exc_flush   (exc_flush),
    .o_div_start   (div_start),
    .o_div_annul   (div_annul),
    .o_stall_div   (w_stall_div),
    .o_div_timeout (div_timeout)
  );

  assign stallF = w_lwstall || w_branchstall || w_stall_div;
  assign stallD = stallF;
  assign stallE = w_stall_div;
  // While the divider holds E, the instruction there must not be replaced by a bubble.
  assign flushE = (w_lwstall || w_branchstall) && !w_stall_div;

endmodule
